// File: rtl/ofm_writeback.sv
// Output feature-map writeback: packs the layer-2 byte stream into 32-bit words,
// buffers them in a small FIFO and writes them to the global BRAM.
module ofm_writeback #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] base_addr_OFM,
    input  logic [31:0] size_OFM,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        wr_grant,
    output logic [31:0] wr_addr_global,
    output logic [31:0] wr_data_global,
    output logic        we_global,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] base_q;
    logic [31:0] size_q;
    logic [31:0] bytes_q;
    logic [31:0] words_q;
    logic [31:0] pack_q, pack_d;
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] mem [FIFO_DEPTH];

    logic        fifo_full;
    logic        fifo_empty;
    logic        ready;
    logic        accept;
    logic        last_byte;
    logic        push;
    logic        pop;
    logic        start_go;
    logic [1:0]  lane;
    logic [31:0] words_total;

    assign fifo_full   = (cnt_q == DEPTH_C);
    assign fifo_empty  = (cnt_q == '0);
    assign ready       = (state_q == S_RUN) && !fifo_full && (bytes_q < size_q);
    assign accept      = in_valid && ready;
    assign lane        = bytes_q[1:0];
    assign last_byte   = ((bytes_q + 32'd1) == size_q);
    assign push        = accept && ((lane == 2'd3) || last_byte);
    assign pop         = !fifo_empty && wr_grant;
    assign start_go    = (state_q == S_IDLE) && start;
    assign words_total = {2'b00, size_q[31:2]} + {31'b0, |size_q[1:0]};

    // Lane 0 starts a fresh word so a partial final word is zero-filled.
    always_comb begin
        pack_d = (lane == 2'd0) ? 32'd0 : pack_q;
        pack_d[{lane, 3'b000} +: 8] = in_data;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (size_OFM == 32'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept && last_byte) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((words_q == words_total) && fifo_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q  <= '0;
            size_q  <= '0;
            bytes_q <= '0;
            words_q <= '0;
            pack_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else if (start_go) begin
            base_q  <= base_addr_OFM;
            size_q  <= size_OFM;
            bytes_q <= '0;
            words_q <= '0;
            pack_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                bytes_q <= bytes_q + 32'd1;
                pack_q  <= pack_d;
            end
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q  <= rptr_q + 1'b1;
                words_q <= words_q + 32'd1;
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= pack_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= pop;
            if (pop) begin
                addr_q <= base_q + {words_q[29:0], 2'b00};
                data_q <= mem[rptr_q];
            end
        end
    end

    assign in_ready       = ready;
    assign we_global      = we_q;
    assign wr_addr_global = addr_q;
    assign wr_data_global = data_q;
    assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);

endmodule

// File: tb/tb_ofm_writeback.sv
// Bench for ofm_writeback: directed cases plus randomized transfers checked
// against a byte-level reference of the expected word writes.
module tb_ofm_writeback;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] base_OFM;
    logic [31:0] size_OFM;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_grant;
    logic [31:0] wr_addr_global;
    logic [31:0] wr_data_global;
    logic        we_global;
    logic        busy;
    logic        done;

    ofm_writeback #(.FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr_OFM  (base_OFM),
        .size_OFM       (size_OFM),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .wr_grant       (wr_grant),
        .wr_addr_global (wr_addr_global),
        .wr_data_global (wr_data_global),
        .we_global      (we_global),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int we0, d0, nw, sent, tot;
    logic [7:0]  bmem [64];
    logic [31:0] eq_addr [$];
    logic [31:0] eq_data [$];
    logic [31:0] mon_a, mon_d;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (we_global === 1'b1) begin
            we_cnt++;
            if (eq_addr.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                mon_a = eq_addr.pop_front();
                mon_d = eq_data.pop_front();
                check("wr_addr", wr_addr_global, mon_a);
                check("wr_data", wr_data_global, mon_d);
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            check("busy_at_done", {31'b0, busy}, 32'd0);
        end
    end

    task automatic start_xfer(input logic [31:0] b, input int s);
        logic [31:0] w;
        @(negedge clk);
        start = 1'b1;
        base_OFM = b;
        size_OFM = s;
        in_valid = 1'b0;
        sent = 0;
        tot = s;
        nw = (s + 3) / 4;
        we0 = we_cnt;
        d0 = done_cnt;
        for (int i = 0; i < nw; i++) begin
            w = 32'd0;
            for (int k = 0; k < 4; k++) begin
                if (4 * i + k < s) w[8*k +: 8] = bmem[4*i+k];
            end
            eq_addr.push_back(b + 32'(4 * i));
            eq_data.push_back(w);
        end
        @(negedge clk);
        start = 1'b0;
        base_OFM = $urandom;
        size_OFM = $urandom;
        if (s == 0) check("zero_done", {31'b0, done}, 32'd1);
    endtask

    task automatic feed(input int upto, input int vpct, input int gpct,
                        input int maxc, input bit glitch, input bit must);
        int c = 0;
        bit g = 1'b0;
        while (sent < upto && c < maxc) begin
            @(negedge clk);
            start = 1'b0;
            in_valid = ($urandom_range(99) < vpct);
            in_data = bmem[sent];
            wr_grant = ($urandom_range(99) < gpct);
            if (glitch && sent == 2 && !g) begin
                start = 1'b1;
                base_OFM = 32'hDEAD_0000;
                size_OFM = 32'd3;
                g = 1'b1;
            end
            if (in_valid && in_ready) sent++;
            c++;
        end
        if (must) check("feed_count", sent, upto);
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done(input int gpct);
        int c = 0;
        in_valid = 1'b0;
        while (done_cnt == d0 && c < 600) begin
            @(negedge clk);
            wr_grant = ($urandom_range(99) < gpct);
            c++;
        end
        @(negedge clk);
        check("done_pulses", done_cnt - d0, 32'd1);
        check("done_low", {31'b0, done}, 32'd0);
        check("busy_low", {31'b0, busy}, 32'd0);
        check("we_count", we_cnt - we0, nw);
        check("exp_left", eq_addr.size(), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        base_OFM = '0;
        size_OFM = '0;
        in_data = '0;
        in_valid = 1'b0;
        wr_grant = 1'b0;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_we", {31'b0, we_global}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_addr", wr_addr_global, 32'd0);
        check("rst_data", wr_data_global, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) bmem[i] = 8'(i + 1);
        start_xfer(32'h100, 8);
        check("busy_run", {31'b0, busy}, 32'd1);
        feed(8, 100, 100, 200, 1'b0, 1'b1);
        wait_done(100);

        for (int i = 0; i < 6; i++) bmem[i] = 8'hA0 + 8'(i);
        start_xfer(32'h0000_0200, 6);
        feed(6, 100, 100, 200, 1'b0, 1'b1);
        wait_done(100);

        for (int i = 0; i < 24; i++) bmem[i] = 8'($urandom);
        start_xfer(32'h2000, 24);
        feed(24, 100, 0, 30, 1'b0, 1'b0);
        check("full_accepted", sent, 32'd16);
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        check("full_no_we", we_cnt - we0, 32'd0);
        feed(24, 100, 100, 200, 1'b0, 1'b1);
        wait_done(100);

        start_xfer(32'h3000, 0);
        wait_done(100);

        for (int i = 0; i < 8; i++) bmem[i] = 8'($urandom);
        start_xfer(32'hFFFF_FFFC, 8);
        feed(8, 100, 100, 200, 1'b0, 1'b1);
        wait_done(100);

        for (int i = 0; i < 12; i++) bmem[i] = 8'($urandom);
        start_xfer(32'h5000, 12);
        feed(12, 70, 60, 400, 1'b1, 1'b1);
        wait_done(60);

        for (int i = 0; i < 16; i++) bmem[i] = 8'($urandom);
        start_xfer(32'h6000, 16);
        feed(8, 100, 0, 100, 1'b0, 1'b1);
        #2 reset_n = 1'b0;
        eq_addr.delete();
        eq_data.delete();
        we0 = we_cnt;
        #1;
        check("mid_rst_we", {31'b0, we_global}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_ready", {31'b0, in_ready}, 32'd0);
        check("mid_rst_addr", wr_addr_global, 32'd0);
        wr_grant = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("no_we_after_rst", we_cnt - we0, 32'd0);
        for (int i = 0; i < 4; i++) bmem[i] = 8'($urandom);
        start_xfer(32'h7000, 4);
        feed(4, 100, 100, 200, 1'b0, 1'b1);
        wait_done(100);

        for (int t = 0; t < 15; t++) begin
            int s;
            s = $urandom_range(40, 1);
            for (int i = 0; i < s; i++) bmem[i] = 8'($urandom);
            start_xfer($urandom, s);
            feed(s, $urandom_range(100, 40), $urandom_range(100, 25),
                 2000, (s > 3) && ($urandom_range(1) == 1), 1'b1);
            wait_done($urandom_range(100, 25));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
